// File: rtl/alu4_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU word sequencer.
// The state enum, nibble width and counter-width helper live here.
package alu4_seq_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Ceiling log2, floored at 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) w = i + 1;
      end
      if (w == 0) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/alu4_word_sequencer.sv
// Drives a 4-bit combinational ALU slice one nibble per cycle to execute a wide
// operation, chaining carries between nibbles and assembling the word result.
module alu4_word_sequencer
   import alu4_seq_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [3:0]                   req_op,
   input  logic [NIBBLES*NIBBLE_W-1:0]  req_a,
   input  logic [NIBBLES*NIBBLE_W-1:0]  req_b,
   input  logic                         req_cin,
   input  logic                         req_rin,
   input  logic                         req_msn_first,
   output logic [3:0]                   alu_op,
   output logic [NIBBLE_W-1:0]          alu_a,
   output logic [NIBBLE_W-1:0]          alu_b,
   output logic                         alu_cin,
   output logic                         alu_rin,
   input  logic [NIBBLE_W-1:0]          alu_y,
   input  logic                         alu_cout,
   input  logic                         alu_rout,
   input  logic                         alu_ovf,
   input  logic                         alu_zero,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [NIBBLES*NIBBLE_W-1:0]  rsp_y,
   output logic                         rsp_cout,
   output logic                         rsp_rout,
   output logic                         rsp_ovf,
   output logic                         rsp_zero
);

   localparam int unsigned W    = NIBBLES * NIBBLE_W;
   localparam int unsigned IdxW = clog2(NIBBLES);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [3:0]      op_q, op_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            msn_q, msn_d;
   logic            c_q, c_d;
   logic            r_q, r_d;
   logic [W-1:0]    y_q, y_d;
   logic            zero_q, zero_d;
   logic            cout_q, cout_d;
   logic            rout_q, rout_d;
   logic            ovf_q, ovf_d;

   logic [NIBBLE_W-1:0] a_nib, b_nib;
   logic                last_nib;

   assign last_nib = msn_q ? (idx_q == '0) : (idx_q == IdxLast);

   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
         if (idx_q == IdxW'(i)) begin
            a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
            b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      msn_d   = msn_q;
      c_d     = c_q;
      r_d     = r_q;
      y_d     = y_q;
      zero_d  = zero_q;
      cout_d  = cout_q;
      rout_d  = rout_q;
      ovf_d   = ovf_q;
      alu_op  = '0;
      alu_a   = '0;
      alu_b   = '0;
      alu_cin = 1'b0;
      alu_rin = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d = StRun;
               op_d    = req_op;
               a_d     = req_a;
               b_d     = req_b;
               msn_d   = req_msn_first;
               c_d     = req_cin;
               r_d     = req_rin;
               idx_d   = req_msn_first ? IdxLast : '0;
               zero_d  = 1'b1;
            end
         end
         StRun: begin
            alu_op  = op_q;
            alu_a   = a_nib;
            alu_b   = b_nib;
            // c_q/r_q hold the captured carries on the first nibble, then the chain.
            alu_cin = c_q;
            alu_rin = r_q;
            c_d     = alu_cout;
            r_d     = alu_rout;
            zero_d  = zero_q & alu_zero;
            for (int unsigned i = 0; i < NIBBLES; i++) begin
               if (idx_q == IdxW'(i)) y_d[i*NIBBLE_W +: NIBBLE_W] = alu_y;
            end
            if (last_nib) begin
               state_d = StDone;
               idx_d   = '0;
               cout_d  = alu_cout;
               rout_d  = alu_rout;
               // Overflow is only meaningful when the sign nibble is processed last.
               ovf_d   = ~msn_q & alu_ovf;
            end else begin
               idx_d = msn_q ? idx_q - 1'b1 : idx_q + 1'b1;
            end
         end
         StDone: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StDone);
   assign rsp_y     = y_q;
   assign rsp_cout  = cout_q;
   assign rsp_rout  = rout_q;
   assign rsp_ovf   = ovf_q;
   assign rsp_zero  = zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         msn_q   <= 1'b0;
         c_q     <= 1'b0;
         r_q     <= 1'b0;
         y_q     <= '0;
         zero_q  <= 1'b0;
         cout_q  <= 1'b0;
         rout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         msn_q   <= msn_d;
         c_q     <= c_d;
         r_q     <= r_d;
         y_q     <= y_d;
         zero_q  <= zero_d;
         cout_q  <= cout_d;
         rout_q  <= rout_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_alu4_word_sequencer.sv
// Bench for alu4_word_sequencer: a two-mode ALU model closes the loop, a vector
// table plus corner-case sequences feed a response scoreboard.
module tb_alu4_word_sequencer;

   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W = 16;
   localparam logic [3:0] OpAdd = 4'h1;
   localparam logic [3:0] OpShr = 4'h2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_ready;
   logic [3:0]   req_op;
   logic [W-1:0] req_a, req_b;
   logic         req_cin, req_rin, req_msn_first;
   logic [3:0]   alu_op, alu_a, alu_b, alu_y;
   logic         alu_cin, alu_rin, alu_cout, alu_rout, alu_ovf, alu_zero;
   logic         rsp_valid, rsp_ready;
   logic [W-1:0] rsp_y;
   logic         rsp_cout, rsp_rout, rsp_ovf, rsp_zero;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         rin;
      logic         msn;
      logic [W-1:0] y;
      logic         cout;
      logic         rout;
      logic         ovf;
      logic         zero;
   } vec_t;

   typedef struct {
      logic [W-1:0] y;
      logic         cout;
      logic         rout;
      logic         ovf;
      logic         zero;
   } exp_t;

   vec_t vecs [8];
   exp_t sb_q [$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu4_word_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_cin       (req_cin),
      .req_rin       (req_rin),
      .req_msn_first (req_msn_first),
      .alu_op        (alu_op),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_cin       (alu_cin),
      .alu_rin       (alu_rin),
      .alu_y         (alu_y),
      .alu_cout      (alu_cout),
      .alu_rout      (alu_rout),
      .alu_ovf       (alu_ovf),
      .alu_zero      (alu_zero),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_y         (rsp_y),
      .rsp_cout      (rsp_cout),
      .rsp_rout      (rsp_rout),
      .rsp_ovf       (rsp_ovf),
      .rsp_zero      (rsp_zero)
   );

   // ALU slice model: add mode and right-shift-through-rotate-carry mode.
   logic [4:0] alu_sum;
   always_comb begin
      alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      alu_y    = '0;
      alu_cout = 1'b0;
      alu_rout = 1'b0;
      alu_ovf  = 1'b0;
      alu_zero = 1'b0;
      if (alu_op == OpAdd) begin
         alu_y    = alu_sum[3:0];
         alu_cout = alu_sum[4];
         alu_ovf  = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
         alu_zero = (alu_sum[3:0] == 4'h0);
      end else if (alu_op == OpShr) begin
         alu_y    = {alu_rin, alu_a[3:1]};
         alu_rout = alu_a[0];
         alu_zero = ({alu_rin, alu_a[3:1]} == 4'h0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=%0h required=none", rsp_y);
         end else begin
            mon_e = sb_q.pop_front();
            check("rsp_y", 32'(rsp_y), 32'(mon_e.y));
            check("rsp_cout", 32'(rsp_cout), 32'(mon_e.cout));
            check("rsp_rout", 32'(rsp_rout), 32'(mon_e.rout));
            check("rsp_ovf", 32'(rsp_ovf), 32'(mon_e.ovf));
            check("rsp_zero", 32'(rsp_zero), 32'(mon_e.zero));
         end
      end
   end

   function automatic exp_t to_exp(input vec_t v);
      exp_t e;
      e.y = v.y; e.cout = v.cout; e.rout = v.rout; e.ovf = v.ovf; e.zero = v.zero;
      return e;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_ready_wait", 32'(req_ready), 32'd1);
   endtask

   task automatic set_req(input vec_t v);
      req_op = v.op; req_a = v.a; req_b = v.b;
      req_cin = v.cin; req_rin = v.rin; req_msn_first = v.msn;
      req_valid = 1'b1;
   endtask

   task automatic scramble_req();
      req_valid = 1'b0;
      req_op = 4'($urandom); req_a = W'($urandom); req_b = W'($urandom);
      req_cin = 1'($urandom); req_rin = 1'($urandom); req_msn_first = 1'($urandom);
   endtask

   // Counts negedges after the accept edge until rsp_valid is seen.
   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 40);
      check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
   endtask

   initial begin
      int lat;
      int cnt;
      vec_t v;
      logic [3:0] exp_a [4];
      logic       exp_rin [4];

      //        op     a         b         cin   rin   msn   y         cout  rout  ovf   zero
      vecs[0] = '{OpAdd, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{OpAdd, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{OpAdd, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{OpShr, 16'h8421, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hC210, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{OpAdd, 16'h0007, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{OpAdd, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{OpShr, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{OpAdd, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};

      rst_n = 1'b0;
      rsp_ready = 1'b1;
      scramble_req();
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_y", 32'(rsp_y), 32'd0);
      check("rst_rsp_flags", {28'd0, rsp_cout, rsp_rout, rsp_ovf, rsp_zero}, 32'd0);
      check("rst_alu", {19'd0, alu_op, alu_a, alu_b, alu_cin, alu_rin}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Table: each vector accepted, scoreboarded, latency checked.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         wait_ready();
         set_req(vecs[i]);
         sb_q.push_back(to_exp(vecs[i]));
         @(posedge clk); #1;
         scramble_req();
         wait_rsp(lat);
         check("latency", 32'(lat), 32'(NIBBLES + 1));
         @(posedge clk); #1;
      end

      // MSN-first shift: nibble order on alu_a and rotate-carry chaining on alu_rin.
      exp_a[0] = 4'h8; exp_a[1] = 4'h4; exp_a[2] = 4'h2; exp_a[3] = 4'h1;
      exp_rin[0] = 1'b1; exp_rin[1] = 1'b0; exp_rin[2] = 1'b0; exp_rin[3] = 1'b0;
      wait_ready();
      set_req(vecs[3]);
      sb_q.push_back(to_exp(vecs[3]));
      @(posedge clk); #1;
      scramble_req();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("alu_a_seq", 32'(alu_a), 32'(exp_a[k]));
         check("alu_rin_seq", 32'(alu_rin), 32'(exp_rin[k]));
      end
      wait_rsp(lat);
      @(posedge clk); #1;

      // Backpressure: response held, new request ignored until handshake.
      rsp_ready = 1'b0;
      wait_ready();
      set_req(vecs[0]);
      sb_q.push_back(to_exp(vecs[0]));
      @(posedge clk); #1;
      scramble_req();
      wait_rsp(lat);
      @(posedge clk); #1;
      v = '{OpAdd, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0};
      set_req(v);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_rsp_y", 32'(rsp_y), 32'h0100);
         check("bp_flags", {28'd0, rsp_cout, rsp_rout, rsp_ovf, rsp_zero}, 32'd0);
         @(posedge clk); #1;
      end
      sb_q.push_back(to_exp(v));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_idle_after_hs", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      check("bp_second_accepted", 32'(req_ready), 32'd0);
      scramble_req();
      wait_rsp(lat);
      check("bp_latency", 32'(lat), 32'(NIBBLES + 1));
      @(posedge clk); #1;

      // Throughput with req_valid and rsp_ready held high.
      wait_ready();
      set_req(vecs[5]);
      sb_q.push_back(to_exp(vecs[5]));
      sb_q.push_back(to_exp(vecs[5]));
      @(posedge clk); #1;
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!req_ready && cnt < 40);
      check("throughput", 32'(cnt + 1), 32'(NIBBLES + 2));
      @(posedge clk); #1;
      check("tp_second_accepted", 32'(req_ready), 32'd0);
      scramble_req();
      wait_rsp(lat);
      @(posedge clk); #1;

      // Reset during the second RUN cycle discards the operation.
      wait_ready();
      set_req(vecs[0]);
      @(posedge clk); #1;
      scramble_req();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_req_ready", 32'(req_ready), 32'd1);
      check("mid_rst_alu", {19'd0, alu_op, alu_a, alu_b, alu_cin, alu_rin}, 32'd0);
      check("mid_rst_rsp_y", 32'(rsp_y), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
      wait_ready();
      set_req(vecs[5]);
      sb_q.push_back(to_exp(vecs[5]));
      @(posedge clk); #1;
      scramble_req();
      wait_rsp(lat);
      check("post_rst_latency", 32'(lat), 32'(NIBBLES + 1));
      @(posedge clk); #1;
      @(posedge clk); #1;

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu4_word_sequencer.md
Name: alu4_word_sequencer

Overview:
- Initiator/driver for the 4-bit combinational ALU slice. Accepts one wide operation request (opcode, two NIBBLES×4-bit operands, carry inputs) over a valid/ready handshake.
- Issues the operation to the ALU one nibble per cycle, chaining math and rotate carries between nibbles, and assembles the wide result and flags.
- Returns the result over a valid/ready response channel. Sits between the top-level control logic and the ALU slice.

Parameters:
- NIBBLES, 4, number of 4-bit slices per word (word width W = 4*NIBBLES); legal range 2..8.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request offered
- req_ready  output  1  request accepted when high with req_valid
- req_op  input  4  ALU opcode, held for the whole operation
- req_a  input  W  operand A
- req_b  input  W  operand B
- req_cin  input  1  math carry into first nibble
- req_rin  input  1  rotate carry into first nibble
- req_msn_first  input  1  1 = process most-significant nibble first (right shifts/rotates); 0 = LSN first
- alu_op  output  4  opcode to ALU
- alu_a  output  4  A nibble to ALU
- alu_b  output  4  B nibble to ALU
- alu_cin  output  1  math carry to ALU
- alu_rin  output  1  rotate carry to ALU
- alu_y  input  4  ALU result nibble (combinational, same cycle)
- alu_cout  input  1  ALU math carry out
- alu_rout  input  1  ALU rotate carry out
- alu_ovf  input  1  ALU signed overflow
- alu_zero  input  1  ALU nibble-zero flag
- rsp_valid  output  1  result available
- rsp_ready  input  1  result consumed when high with rsp_valid
- rsp_y  output  W  assembled result
- rsp_cout  output  1  final math carry
- rsp_rout  output  1  final rotate carry
- rsp_ovf  output  1  overflow of the last nibble processed; forced 0 when msn_first
- rsp_zero  output  1  AND of all nibble zero flags

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, req_ready 1 (combinational from IDLE), rsp_valid 0, rsp_y 0, all rsp flags 0, counter 0, all alu_* outputs 0.
- States:
  - IDLE: req_ready=1. On req_valid, capture op/a/b/cin/rin/msn_first, set idx to 0 (LSN first) or NIBBLES-1 (MSN first), go to RUN.
  - RUN: alu_op=captured op and alu_a/alu_b = nibble idx of the captured operands.
    - First RUN cycle: alu_cin=req_cin, alu_rin=req_rin (captured values).
    - Later cycles: alu_cin/alu_rin = registered alu_cout/alu_rout of the previous cycle.
    - Each cycle writes alu_y into result nibble idx and ANDs alu_zero into the zero accumulator.
    - idx steps +1 (LSN first) or -1 (MSN first).
    - After the NIBBLES-th RUN cycle, latch final cout/rout/ovf and go to DONE.
  - DONE: rsp_valid=1 and rsp_* are stable. On rsp_ready, go to IDLE.
- Timing and throughput:
  - Latency: accept edge → exactly NIBBLES RUN cycles → rsp_valid asserted in the following cycle.
  - Throughput: one operation per NIBBLES+2 cycles with rsp_ready held high.
- Handshake rules:
  - req_ready is low in RUN and DONE; req_valid there is ignored and not queued.
  - rsp_* hold unchanged while rsp_valid && !rsp_ready. No new request is accepted until the response is taken.
  - Request inputs may change freely after acceptance; only the captured copies are used.
- Outputs outside RUN: alu_* driven to 0 in IDLE and DONE.
- Boundary conditions:
  - idx never wraps; a counter value outside 0..NIBBLES-1 is unreachable.
  - Reset mid-RUN or mid-DONE: the operation is discarded, all outputs return to reset values immediately, and no response is issued.
  - Zero accumulator is initialised to 1 at accept.
  - rsp_ovf is taken from the final nibble only when LSN first (the sign nibble); otherwise it is 0.

Decomposition:
- Shared package alu4_seq_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - NIBBLE_W=4;
  - the counter width function clog2(NIBBLES).
- No sub-module: datapath (nibble mux, result demux, carry registers) and FSM live in one module. The ALU slice is instantiated by the parent, not inside this block.

Test Plan:
- Bench setup: the bench uses an ALU model with two modes:
  - add mode: y=a+b+cin, cout, signed ovf, zero;
  - shift mode: y={rin,a[3:1]}, rout=a[0].
- NIBBLES=4, add, A=0x00FF, B=0x0001, cin=0 → rsp_y=0x0100, cout=0, zero=0, ovf=0; rsp_valid 5 cycles after accept.
- Add, A=0xFFFF, B=0x0001, cin=0 → rsp_y=0x0000, cout=1, zero=1, ovf=0.
- Add, A=0x7FFF, B=0x0001 → rsp_y=0x8000, ovf=1, cout=0.
- Shift mode, msn_first=1, A=0x8421, rin=1 → rsp_y=0xC210, rout=1, ovf=0; alu_a sequence 8,4,2,1.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE while req_valid=1 with changed operands → rsp_y and flags constant, req_ready=0, second request accepted only after the rsp handshake.
- Assert rst_n low during the 2nd RUN cycle → rsp_valid=0, req_ready=1, alu_* = 0 immediately; the next request completes correctly.
